// File: rtl/load_store_unit.sv
// Load/store sequencer between the multicycle datapath and data memory:
// req/ack handshake with wait states, sub-word lane handling, fault and timeout flags.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        timeout,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        to_q, to_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sx_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        legal;
    logic        accept;
    logic        hit_limit;

    function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_replicate(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] a, input logic sx);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return sx ? 32'(b) : {24'b0, b};
            2'b01:   return sx ? 32'(h) : {16'b0, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr[0];
            2'b10:   legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign accept    = (state_q == S_IDLE) && start;
    assign hit_limit = ((cnt_q + 8'd1) == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

    // Ack in the last allowed wait cycle still wins over the timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    if (legal) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                        mis_d   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (hit_limit) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        misalign  = done && mis_q;
        timeout   = done && to_q;
        mem_req   = (state_q == S_REQ);
        mem_we    = mem_req && we_q;
        mem_be    = mem_req ? lane_enables(size_q, addr_q[1:0]) : 4'b0000;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = store_replicate(size_q, wdata_q);
        rdata     = rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sx_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= we;
                size_q  <= size;
                sx_q    <= sign_ext;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if ((state_q == S_REQ) && mem_ack && !we_q) begin
                rdata_q <= load_extend(mem_rdata, size_q, addr_q[1:0], sx_q);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-cycle comparison against a transaction-level
// model plus literal expectations for each directed access.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic        timeout;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;
    int ack_wait = 255;
    int rsp_cnt = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .misalign(misalign), .timeout(timeout), .rdata(rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] a, input logic sx);
        logic [31:0] v;
        int sh;
        case (sz)
            2'd0: begin
                sh = 8 * int'(a);
                v = (w >> sh) & 32'h0000_00FF;
                if (sx && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                sh = a[1] ? 16 : 0;
                v = (w >> sh) & 32'h0000_FFFF;
                if (sx && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return 4'b0001 << a;
        if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return {24'b0, w[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'b0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    logic        m_active, m_done, m_mis, m_to, m_we, m_sx;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_waits;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0; m_done <= 1'b0; m_mis <= 1'b0; m_to <= 1'b0;
            m_we <= 1'b0; m_sx <= 1'b0; m_size <= 2'd0;
            m_addr <= 32'd0; m_wdata <= 32'd0; m_rdata <= 32'd0; m_waits <= 0;
        end else begin
            m_done <= 1'b0;
            m_mis  <= 1'b0;
            m_to   <= 1'b0;
            if (!m_active && !m_done && start) begin
                m_we <= we; m_sx <= sign_ext; m_size <= size; m_addr <= addr; m_wdata <= wdata;
                if ((size == 2'd0) || (size == 2'd1 && !addr[0]) || (size == 2'd2 && addr[1:0] == 2'd0)) begin
                    m_active <= 1'b1;
                    m_waits  <= 0;
                end else begin
                    m_done <= 1'b1;
                    m_mis  <= 1'b1;
                end
            end else if (m_active) begin
                if (mem_ack) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    if (!m_we) m_rdata <= m_ext(mem_rdata, m_size, m_addr[1:0], m_sx);
                end else if (m_waits + 1 == TO) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_to     <= 1'b1;
                end else begin
                    m_waits <= m_waits + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 32'(busy), 32'(m_active || m_done));
            chk("done", 32'(done), 32'(m_done));
            chk("misalign", 32'(misalign), 32'(m_mis));
            chk("timeout", 32'(timeout), 32'(m_to));
            chk("rdata", rdata, m_rdata);
            chk("mem_req", 32'(mem_req), 32'(m_active));
            chk("mem_we", 32'(mem_we), 32'(m_active && m_we));
            chk("mem_be", 32'(mem_be), m_active ? 32'(m_be(m_size, m_addr[1:0])) : 32'd0);
            if (m_active) begin
                chk("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
                chk("mem_wdata", mem_wdata, m_wd(m_size, m_wdata));
            end
        end
    end

    // Memory responder: acks after ack_wait wait states of an outstanding request.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mem_ack = (rsp_cnt == ack_wait);
                rsp_cnt++;
            end else begin
                mem_ack = 1'b0;
                rsp_cnt = 0;
            end
        end
    end

    task automatic access(input string nm, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, input int exp_lat, input int exp_req,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic exp_mis, input logic exp_to, input logic [31:0] exp_rd);
        int lat;
        int req_cnt;
        bit got;
        @(negedge clk);
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; mem_rdata = rd;
        ack_wait = waits; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; req_cnt = 0; got = 0;
        for (int k = 0; k < 300; k++) begin
            if (mem_req) begin
                if (req_cnt == 0) begin
                    chk({nm, "_be"}, 32'(mem_be), 32'(exp_be));
                    chk({nm, "_addr"}, mem_addr, {a[31:2], 2'b00});
                    chk({nm, "_we"}, 32'(mem_we), 32'(w));
                    chk({nm, "_wdata"}, mem_wdata, exp_wd);
                end
                req_cnt++;
            end
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_req_cycles"}, req_cnt, exp_req);
        chk({nm, "_misalign"}, 32'(misalign), 32'(exp_mis));
        chk({nm, "_timeout"}, 32'(timeout), 32'(exp_to));
        chk({nm, "_rdata"}, rdata, exp_rd);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        //     name     we    sz     sx    addr          wdata         mem_rdata     wt  lat req be    wdata exp     mis   to    rdata exp
        access("lw",    1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0,  2,  1,  4'hF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF);
        access("lbs",   1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80123456, 3,  5,  4,  4'h8, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80);
        access("lbu",   1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80123456, 3,  5,  4,  4'h8, 32'h0,        1'b0, 1'b0, 32'h00000080);
        access("sh",    1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h11111111, 1,  3,  2,  4'hC, 32'hABCDABCD, 1'b0, 1'b0, 32'h00000080);
        access("lw_mis",1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        32'h22222222, 0,  1,  0,  4'hF, 32'h0,        1'b1, 1'b0, 32'h00000080);
        access("sz11",  1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h33333333, 0,  1,  0,  4'hF, 32'h0,        1'b1, 1'b0, 32'h00000080);
        access("tmo",   1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        32'h44444444, 255,5,  4,  4'hF, 32'h0,        1'b0, 1'b1, 32'h00000080);
        @(negedge clk);
        chk("tmo_idle_busy", 32'(busy), 32'd0);
        access("lhs_hi",1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h80017FFF, 0,  2,  1,  4'hC, 32'h0,        1'b0, 1'b0, 32'hFFFF8001);
        access("lhs_lo",1'b0, 2'd1, 1'b1, 32'h100, 32'h0,        32'h1234ABCD, 0,  2,  1,  4'h3, 32'h0,        1'b0, 1'b0, 32'hFFFFABCD);
        access("sb",    1'b1, 2'd0, 1'b0, 32'h001, 32'h123456A5, 32'h55555555, 2,  4,  3,  4'h2, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hFFFFABCD);
        access("sw_lst",1'b1, 2'd2, 1'b0, 32'h040, 32'hCAFEF00D, 32'h66666666, 3,  5,  4,  4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'hFFFFABCD);
        access("sh_mis",1'b1, 2'd1, 1'b0, 32'h203, 32'h0000BEEF, 32'h77777777, 0,  1,  0,  4'hC, 32'h0,        1'b1, 1'b0, 32'hFFFFABCD);

        // Reset in the middle of a waiting request.
        @(negedge clk);
        we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h500; wdata = 32'd0;
        ack_wait = 255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("prerst_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        chk("midrst_done_hold", 32'(done), 32'd0);
        reset = 1'b0;
        access("lw_post",1'b0, 2'd2, 1'b0, 32'h000, 32'h0,       32'h0BADF00D, 0,  2,  1,  4'hF, 32'h0,        1'b0, 1'b0, 32'h0BADF00D);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
